alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, handshaked successor of the team's combinational ALU.
- Single-cycle ops complete through one registered output stage; MUL runs on an iterative shift-add unit.
- Sits between an issue stage (valid/ready in) and a writeback stage (valid/ready out).
- Adds flags (zero/negative/carry/overflow), illegal-opcode reporting and backpressure, none of which the combinational ALU has.

Parameters:
- WIDTH, 32, operand/result width (>=8, power of 2).
- TAG_W, 4, width of opaque tag carried from input to output.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  4  opcode (alu_pkg::alu_op_e).
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_result  out  WIDTH  result.
- out_tag  out  TAG_W  tag of this result.
- out_flags  out  4  {negative, zero, carry, overflow}.
- out_illegal  out  1  opcode unsupported.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_result=0, out_tag=0, out_flags=0, out_illegal=0, FSM=IDLE, multiplier state cleared.
- in_ready=0 during reset. Assert mid-MUL aborts the operation; nothing is emitted.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed, result 1/0), 6 SLTU.
  - 7 SLL, 8 SRL, 9 SRA; shift amount = in_b[$clog2(WIDTH)-1:0], upper bits ignored.
  - 10 MUL: low WIDTH bits of a*b.
  - 11-15 reserved.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. Inputs are sampled only on transfer. Outputs are stable while out_valid&&!out_ready.
- FSM IDLE:
  - in_ready = !out_valid || out_ready.
  - Accepted single-cycle op: result registered, out_valid=1 next cycle (latency 1).
  - With out_ready held high, one op per cycle.
- FSM IDLE, MUL accepted: go to MUL; counter loads WIDTH-1; in_ready=0.
- FSM MUL:
  - One partial-product step per cycle.
  - When counter==0: write the result, out_valid=1, return to IDLE.
  - out_valid rises exactly WIDTH cycles after the accept edge.
  - A prior result still held in the output register blocks MUL entry: MUL is accepted only when in_ready is high.
- Flags:
  - zero = (result==0); negative = result[WIDTH-1].
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB: carry = no-borrow (a>=b unsigned); overflow = signed overflow.
  - All other ops: carry=0, overflow=0.
- Reserved opcode: latency 1, result=0, out_illegal=1, flags={0,1,0,0}.
- Arithmetic wraps modulo 2^WIDTH. Shift by 0 passes A unchanged. SRA by WIDTH-1 yields all sign bits.

Optional Feature:
- ALU_PIPE_MUL_EN defined: opcode 10 executes on alu_mul_iter as described.
- Not defined: multiplier not instantiated; opcode 10 is treated as reserved (latency 1, out_illegal=1, result 0); FSM has no MUL state.

Decomposition:
- alu_pkg:
  - alu_op_e enum (4-bit, values above).
  - alu_flags_t packed struct {neg, zero, carry, ovf}.
  - Localparam for flag bit indices.
  - Function is_legal_op(op, mul_en).
- Sub-module alu_mul_iter:
  - Inputs: start, a, b. Outputs: busy, done pulse, product[WIDTH-1:0].
  - Owns the counter and shift registers.
  - Instantiated only under ALU_PIPE_MUL_EN.

Test Plan (WIDTH=32):
- ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> next cycle result 0x00000000, flags zero=1, carry=1, ovf=0.
- SUB 0x80000000-0x00000001 -> result 0x7FFFFFFF, ovf=1, carry=1, neg=0. SLT 0xFFFFFFFF,0x00000001 -> 1; SLTU same operands -> 0.
- Back-to-back: 8 ops on consecutive cycles with out_ready=1 -> 8 results on consecutive cycles, tags in order.
- Backpressure: out_ready=0 for 5 cycles after the first result -> in_ready=0, outputs stable; release -> next input accepted the same cycle.
- MUL 0x00010003*0x00020005 (ALU_PIPE_MUL_EN) -> in_ready low 32 cycles, out_valid 32 cycles after accept, result 0x000B000F. Reset pulse at cycle 10 of a MUL -> no result, out_valid=0, in_ready=1 after release.
- Opcode 12, and opcode 10 without the macro -> out_illegal=1, result 0, flags zero=1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag layout and legality check.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic neg;
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

    // Opcodes 11-15 are always reserved; MUL is legal only when the multiplier is built.
    function automatic logic is_legal_op(logic [3:0] op, logic mul_en);
        return (op <= OP_SRA) || (mul_en && (op == OP_MUL));
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits of a*b.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    // The final step's partial product is folded in combinationally so done and product align.
    assign acc_nxt = acc + (b_sh[0] ? a_sh : '0);
    assign done    = busy && (cnt == '0);
    assign product = acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(WIDTH - 1);
            a_sh <= a;
            b_sh <= b;
            acc  <= '0;
        end else if (busy) begin
            acc  <= acc_nxt;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - 1'b1;
            if (cnt == '0)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with one registered output stage and flag/illegal reporting.
// Define ALU_PIPE_MUL_EN to execute opcode 10 on the iterative multiplier; otherwise it is reserved.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic             out_illegal
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;
`ifdef ALU_PIPE_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    function automatic alu_flags_t make_flags(logic [WIDTH-1:0] r, logic c, logic v);
        alu_flags_t f;
        f.neg   = r[WIDTH-1];
        f.zero  = (r == '0);
        f.carry = c;
        f.ovf   = v;
        return f;
    endfunction

    alu_op_e                  op_p0;
    logic                     legal_p0;
    logic                     accept_p0;
    logic                     single_p0;
    logic signed [WIDTH-1:0]  a_s_p0;
    logic signed [WIDTH-1:0]  b_s_p0;
    logic [SH_W-1:0]          shamt_p0;
    logic [WIDTH:0]           sum_p0;
    logic [WIDTH:0]           diff_p0;
    logic [WIDTH-1:0]         result_p0;
    logic                     carry_p0;
    logic                     ovf_p0;
    alu_flags_t               flags_p0;

    logic                     vld_p1;
    logic [WIDTH-1:0]         result_p1;
    logic [TAG_W-1:0]         tag_p1;
    alu_flags_t               flags_p1;
    logic                     illegal_p1;

    assign op_p0     = alu_op_e'(in_op);
    assign legal_p0  = is_legal_op(in_op, MUL_EN);
    assign accept_p0 = in_valid && in_ready;
    assign a_s_p0    = $signed(in_a);
    assign b_s_p0    = $signed(in_b);
    assign shamt_p0  = in_b[SH_W-1:0];
    assign sum_p0    = {1'b0, in_a} + {1'b0, in_b};
    assign diff_p0   = {1'b0, in_a} - {1'b0, in_b};

    // ---- stage p0: combinational execute of single-cycle ops ----
    always_comb begin
        result_p0 = '0;
        carry_p0  = 1'b0;
        ovf_p0    = 1'b0;
        if (legal_p0) begin
            case (op_p0)
                OP_ADD: begin
                    result_p0 = sum_p0[WIDTH-1:0];
                    carry_p0  = sum_p0[WIDTH];
                    ovf_p0    = (in_a[MSB] == in_b[MSB]) && (sum_p0[MSB] != in_a[MSB]);
                end
                OP_SUB: begin
                    result_p0 = diff_p0[WIDTH-1:0];
                    carry_p0  = !diff_p0[WIDTH];
                    ovf_p0    = (in_a[MSB] != in_b[MSB]) && (diff_p0[MSB] != in_a[MSB]);
                end
                OP_AND:  result_p0 = in_a & in_b;
                OP_OR:   result_p0 = in_a | in_b;
                OP_XOR:  result_p0 = in_a ^ in_b;
                OP_SLT:  result_p0 = WIDTH'(a_s_p0 < b_s_p0);
                OP_SLTU: result_p0 = WIDTH'(in_a < in_b);
                OP_SLL:  result_p0 = in_a << shamt_p0;
                OP_SRL:  result_p0 = in_a >> shamt_p0;
                OP_SRA:  result_p0 = a_s_p0 >>> shamt_p0;
                default: result_p0 = '0;
            endcase
        end
        flags_p0 = make_flags(result_p0, carry_p0, ovf_p0);
    end

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {ST_IDLE, ST_MUL} state_e;

    state_e           state;
    state_e           state_nxt;
    logic             is_mul_p0;
    logic             idle_ready;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [TAG_W-1:0] mul_tag;

    assign is_mul_p0 = legal_p0 && (op_p0 == OP_MUL);
    assign single_p0 = accept_p0 && !is_mul_p0;
    assign in_ready  = rst_n && idle_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        idle_ready = 1'b0;
        mul_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                idle_ready = !vld_p1 || out_ready;
                if (in_valid && rst_n && idle_ready && is_mul_p0) begin
                    mul_start = 1'b1;
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_done || !mul_busy)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mul_tag <= '0;
        else if (mul_start)
            mul_tag <= in_tag;
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign single_p0 = accept_p0;
    assign in_ready  = rst_n && (!vld_p1 || out_ready);
`endif

    // ---- stage p1: output register, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            result_p1  <= '0;
            tag_p1     <= '0;
            flags_p1   <= '0;
            illegal_p1 <= 1'b0;
        end else if (single_p0) begin
            vld_p1     <= 1'b1;
            result_p1  <= result_p0;
            tag_p1     <= in_tag;
            flags_p1   <= flags_p0;
            illegal_p1 <= !legal_p0;
`ifdef ALU_PIPE_MUL_EN
        end else if (mul_done) begin
            vld_p1     <= 1'b1;
            result_p1  <= mul_product;
            tag_p1     <= mul_tag;
            flags_p1   <= make_flags(mul_product, 1'b0, 1'b0);
            illegal_p1 <= 1'b0;
`endif
        end else if (vld_p1 && out_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign out_valid   = vld_p1;
    assign out_result  = result_p1;
    assign out_tag     = tag_p1;
    assign out_flags   = flags_p1;
    assign out_illegal = illegal_p1;

endmodule
